mon_readout_ctrl: RTL and testbench
===================================

# mon_readout_ctrl

Readout sequencer for the serial monitor-register chain. On a read request it drives the address bus and `latchOut` so the addressed read-only monitor register parallel-loads its value. It then asserts `shiftEn` for NBITS cycles, sampling the shared `shiftIn` line MSB-first, and presents the assembled word with a one-cycle valid strobe. It sits between the command decoder and the bank of monitor registers, and is the only driver of their `addrIn`, `latchOut` and `shiftEn` inputs.

## Interface
Parameters:
- `NBITS`, default 32: word length shifted per read. It is also the width of `rdData`.

Ports:
- `bclk`  in  1  system clock; all logic is on the rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `rdReq`  in  1  read request. Sampled only in IDLE.
- `rdAddr`  in  8  register address to read. Captured together with `rdReq`.
- `busy`  out  1  high in every state except IDLE.
- `rdValid`  out  1  one-cycle strobe: `rdData` has just been updated.
- `rdData`  out  NBITS  last completed read word. Held until the next completion.
- `addrOut`  out  8  address to the monitor registers' `addrIn`.
- `latchOut`  out  1  load strobe to the monitor registers.
- `shiftEn`  out  1  shift strobe to the monitor registers.
- `shiftIn`  in  1  OR of all monitor-register `shiftOut` lines. Registered at source.

## Operation
- FSM states: IDLE, LATCH, SHIFT, DONE.
  - Encoding is one-hot or binary.
  - `latchOut`, `shiftEn`, `rdValid` and `busy` are decoded from state flops only. They are glitch-free and combinationally independent of the inputs.
- IDLE
  - `rdReq`=1 at an edge: `addrOut` <= `rdAddr`, accumulator <= 0, go to LATCH.
  - Otherwise stay in IDLE.
- LATCH
  - `latchOut`=1 for exactly one cycle.
  - Bit counter <= 0, go to SHIFT.
- SHIFT
  - `shiftEn`=1.
  - Each edge: accumulator <= {accumulator[NBITS-2:0], `shiftIn`}, counter <= counter+1.
  - On the edge where counter == NBITS-1:
    - `rdData` <= {accumulator[NBITS-2:0], `shiftIn`}, so the final bit is included.
    - Go to DONE.
- DONE
  - `rdValid`=1 for one cycle, then go to IDLE.
- Counter width is $clog2(NBITS). The counter does not wrap within a read.
- `rdReq` in LATCH, SHIFT or DONE is ignored: no queuing, and `addrOut`/`rdData` are unaffected. A held `rdReq` re-triggers only once IDLE is re-entered.
- `addrOut` holds its value after the read completes. It changes only on an accepted request.
- Data order is MSB first: the first sampled bit lands in `rdData[NBITS-1]`.
- Unmatched address: no register loads and `shiftIn` stays 0, so `rdData` = 0. This is not flagged as an error.

## Timing
- Reset (`rstb`=0, asynchronous, immediate):
  - State returns to IDLE.
  - `busy`, `rdValid`, `latchOut`, `shiftEn` = 0.
  - `addrOut` = 8'h00, `rdData` = 0, accumulator and counter = 0.
- Reset mid-read aborts the read: no `rdValid`, and `rdData` is cleared.
- Request accepted at edge E0. Then:
  - `latchOut`=1 in cycle E0..E1.
  - `shiftEn`=1 in cycles E1..E(NBITS+1).
  - `rdData` updates and `rdValid` rises at E(NBITS+1), falls at E(NBITS+2).
- Latency from request edge to `rdValid` is NBITS+1 cycles (33 for NBITS=32).
- `busy` rises at E0 and falls at E(NBITS+2).
- Back-to-back reads with `rdReq` held high: one accepted request every NBITS+3 cycles (35 for NBITS=32).
- `shiftIn` is sampled on the same edges where `shiftEn`=1. This edge alignment is what makes the first sample equal to the register's bit NBITS-1, which is valid after the LATCH edge.

## Test plan
- Reset: assert `rstb` with random inputs -> all outputs 0 and `addrOut`=8'h00. After release with `rdReq`=0 for 50 cycles -> `busy` stays 0.
- Single read, model register at 8'h05 holding 32'hDEADBEEF; `rdReq` pulse with `rdAddr`=8'h05:
  - `latchOut` high 1 cycle with `addrOut`=8'h05, then `shiftEn` high 32 cycles.
  - `rdValid` high 1 cycle, 33 cycles after the request edge, with `rdData`=32'hDEADBEEF.
- Address miss, read 8'h06 (no register) -> `rdData`=32'h00000000, `rdValid` pulses at the same latency.
- Request while busy: during a read of 8'h05=32'h12345678, pulse `rdReq` with `rdAddr`=8'h09 in SHIFT -> `addrOut` stays 8'h05, a single `rdValid` occurs, `rdData`=32'h12345678.
- Back-to-back, `rdReq` held high, registers 8'h01=32'h00000001 and 8'h02=32'h80000000, `rdAddr` switched after the first acceptance -> two `rdValid` pulses 35 cycles apart, with `rdData` 32'h00000001 then 32'h80000000 (MSB/LSB edge bits).
- Reset mid-shift: assert `rstb` at `shiftEn` cycle 10 -> `shiftEn`/`busy` drop immediately, no `rdValid`, `rdData`=0. A following read of 8'h05=32'hA5A5A5A5 returns 32'hA5A5A5A5.

Source files
------------

// File: rtl/mon_readout_ctrl.sv
// mon_readout_ctrl: readout sequencer for the serial monitor-register chain.
// A read request latches the addressed monitor register, shifts its contents
// out MSB-first over NBITS cycles and presents the word with a one-cycle
// rdValid strobe. Strobe outputs come straight from one-hot state flops so
// they are glitch-free and independent of the inputs.

module mon_readout_ctrl #(
    parameter int NBITS = 32
) (
    input  logic             bclk,
    input  logic             rstb,
    input  logic             rdReq,
    input  logic [7:0]       rdAddr,
    output logic             busy,
    output logic             rdValid,
    output logic [NBITS-1:0] rdData,
    output logic [7:0]       addrOut,
    output logic             latchOut,
    output logic             shiftEn,
    input  logic             shiftIn
);

    // Bit counter only needs to reach NBITS-1; it never wraps within a read.
    localparam int            CW       = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    // One-hot so each strobe output is a single flop bit.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        LATCH = 4'b0010,
        SHIFT = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam int S_IDLE  = 0;
    localparam int S_LATCH = 1;
    localparam int S_SHIFT = 2;
    localparam int S_DONE  = 3;

    state_t           state_q, state_d;
    logic [7:0]       addr_q,  addr_d;
    logic [NBITS-1:0] acc_q,   acc_d;
    logic [NBITS-1:0] data_q,  data_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    // Accumulator with the current serial bit appended; used both for the
    // running shift and for the final word so the last bit is not lost.
    logic [NBITS-1:0] acc_shifted;
    assign acc_shifted = {acc_q[NBITS-2:0], shiftIn};

    // State register and datapath flops; reset aborts any read in flight.
    always_ff @(posedge bclk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            addr_q  <= 8'h00;
            acc_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath: requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rdReq) begin
                    addr_d  = rdAddr;
                    acc_d   = '0;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                // Register parallel-loads on this edge; its MSB is on
                // shiftIn for the first SHIFT edge.
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                acc_d = acc_shifted;
                if (cnt_q == CNT_LAST) begin
                    data_d  = acc_shifted;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are single state bits: no decode logic between flop and pin.
    assign busy     = ~state_q[S_IDLE];
    assign latchOut = state_q[S_LATCH];
    assign shiftEn  = state_q[S_SHIFT];
    assign rdValid  = state_q[S_DONE];
    assign addrOut  = addr_q;
    assign rdData   = data_q;

    // State must always be exactly one-hot once out of reset.
    property p_onehot;
        @(posedge bclk) disable iff (!rstb) $onehot(state_q);
    endproperty
    a_onehot: assert property (p_onehot);

    // The counter must not be asked to step beyond its last value.
    property p_no_wrap;
        @(posedge bclk) disable iff (!rstb)
            (state_q == SHIFT) |-> (cnt_q <= CNT_LAST);
    endproperty
    a_no_wrap: assert property (p_no_wrap);

endmodule

// File: tb/tb_mon_readout_ctrl.sv
// Bench for mon_readout_ctrl: a behavioural monitor-register bank drives
// shiftIn; expected words and strobe timing come from the read rules.

module tb_mon_readout_ctrl;

    localparam int NBITS = 32;
    localparam int LAT   = NBITS + 1;   // request edge to rdValid
    localparam int PER   = NBITS + 3;   // back-to-back period

    logic             bclk = 1'b0;
    logic             rstb = 1'b1;
    logic             rdReq = 1'b0;
    logic [7:0]       rdAddr = 8'h00;
    logic             busy, rdValid, latchOut, shiftEn, shiftIn;
    logic [NBITS-1:0] rdData;
    logic [7:0]       addrOut;

    int tests = 0;
    int fails = 0;

    always #5 bclk = ~bclk;

    mon_readout_ctrl #(.NBITS(NBITS)) dut (
        .bclk(bclk), .rstb(rstb), .rdReq(rdReq), .rdAddr(rdAddr),
        .busy(busy), .rdValid(rdValid), .rdData(rdData),
        .addrOut(addrOut), .latchOut(latchOut), .shiftEn(shiftEn),
        .shiftIn(shiftIn)
    );

    // Monitor register bank: contents plus which addresses exist.
    logic [NBITS-1:0] mem [256];
    bit               present [256];
    logic [NBITS-1:0] sr = '0;

    assign shiftIn = sr[NBITS-1];

    always @(posedge bclk) begin
        if (latchOut)     sr <= present[addrOut] ? mem[addrOut] : '0;
        else if (shiftEn) sr <= {sr[NBITS-2:0], 1'b0};
    end

    function automatic logic [NBITS-1:0] expect_word(input logic [7:0] a);
        return present[a] ? mem[a] : '0;
    endfunction

    // Observation record of one watch window.
    int               n_latch, k_latch, n_shift, k_shift0, k_busy_last;
    logic [7:0]       latch_addr;
    int               vk[$];
    logic [NBITS-1:0] vd[$];

    task automatic start_read(input logic [7:0] a);
        @(negedge bclk);
        rdReq  = 1'b1;
        rdAddr = a;
    endtask

    // Observe ncyc cycles after the accepting edge (k=0 is the cycle after it).
    task automatic watch(input int ncyc, input bit hold, input int pk,
                         input logic [7:0] paddr, input logic [7:0] addr2);
        n_latch = 0; k_latch = -1; n_shift = 0; k_shift0 = -1;
        k_busy_last = -1; latch_addr = 8'hxx;
        vk.delete(); vd.delete();
        for (int k = 0; k < ncyc; k++) begin
            @(negedge bclk);
            if (latchOut === 1'b1) begin
                if (n_latch == 0) begin k_latch = k; latch_addr = addrOut; end
                n_latch++;
            end
            if (shiftEn === 1'b1) begin
                if (n_shift == 0) k_shift0 = k;
                n_shift++;
            end
            if (rdValid === 1'b1) begin vk.push_back(k); vd.push_back(rdData); end
            if (busy === 1'b1) k_busy_last = k;
            if (k == 0) begin
                if (hold) rdAddr = addr2;
                else      rdReq  = 1'b0;
            end
            if (k == pk) begin
                rdReq = 1'b1; rdAddr = paddr;
            end else if (pk >= 0 && k == pk + 1) begin
                rdReq = 1'b0;
            end
        end
        rdReq = 1'b0;
    endtask

    task automatic test_reset();
        int busy_seen;
        #2;
        rdReq  = 1'($urandom);
        rdAddr = 8'($urandom);
        rstb   = 1'b0;
        #1;
        tests++; if ({busy, rdValid, latchOut, shiftEn} !== 4'b0000) begin
            fails++; $display("FAIL reset_strobes got=%b want=0000", {busy, rdValid, latchOut, shiftEn});
        end
        tests++; if (rdData !== '0) begin
            fails++; $display("FAIL reset_rdData got=%h want=0", rdData);
        end
        tests++; if (addrOut !== 8'h00) begin
            fails++; $display("FAIL reset_addrOut got=%h want=00", addrOut);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge bclk);
            rdReq = 1'($urandom); rdAddr = 8'($urandom);
        end
        tests++; if (busy !== 1'b0 || addrOut !== 8'h00) begin
            fails++; $display("FAIL reset_held busy=%b addr=%h want 0/00", busy, addrOut);
        end
        @(negedge bclk);
        rdReq = 1'b0;
        rstb  = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge bclk);
            if (busy !== 1'b0) busy_seen++;
        end
        tests++; if (busy_seen != 0) begin
            fails++; $display("FAIL idle_busy got=%0d busy cycles want=0", busy_seen);
        end
    endtask

    task automatic test_single_read();
        mem[8'h05] = 32'hDEADBEEF; present[8'h05] = 1'b1;
        start_read(8'h05);
        watch(LAT + 3, 1'b0, -1, 8'h00, 8'h00);
        tests++; if (n_latch != 1 || k_latch != 0) begin
            fails++; $display("FAIL single_latch got n=%0d k=%0d want n=1 k=0", n_latch, k_latch);
        end
        tests++; if (latch_addr !== 8'h05) begin
            fails++; $display("FAIL single_latch_addr got=%h want=05", latch_addr);
        end
        tests++; if (n_shift != NBITS || k_shift0 != 1) begin
            fails++; $display("FAIL single_shift got n=%0d k=%0d want n=%0d k=1", n_shift, k_shift0, NBITS);
        end
        tests++; if (vk.size() != 1 || vk[0] != LAT) begin
            fails++; $display("FAIL single_valid got n=%0d k=%0d want n=1 k=%0d",
                              vk.size(), (vk.size() > 0) ? vk[0] : -1, LAT);
        end
        tests++; if (vd.size() < 1 || vd[0] !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_data got=%h want=deadbeef", (vd.size() > 0) ? vd[0] : 32'hx);
        end
        tests++; if (k_busy_last != LAT) begin
            fails++; $display("FAIL single_busy_fall got last=%0d want=%0d", k_busy_last, LAT);
        end
        tests++; if (addrOut !== 8'h05 || rdData !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_hold got addr=%h data=%h want 05/deadbeef", addrOut, rdData);
        end
    endtask

    task automatic test_addr_miss();
        present[8'h06] = 1'b0;
        start_read(8'h06);
        watch(LAT + 3, 1'b0, -1, 8'h00, 8'h00);
        tests++; if (vk.size() != 1 || vk[0] != LAT) begin
            fails++; $display("FAIL miss_valid got n=%0d k=%0d want n=1 k=%0d",
                              vk.size(), (vk.size() > 0) ? vk[0] : -1, LAT);
        end
        tests++; if (vd.size() < 1 || vd[0] !== 32'h0) begin
            fails++; $display("FAIL miss_data got=%h want=00000000", (vd.size() > 0) ? vd[0] : 32'hx);
        end
    endtask

    task automatic test_req_while_busy();
        mem[8'h05] = 32'h12345678; present[8'h05] = 1'b1;
        mem[8'h09] = 32'hFFFF0000; present[8'h09] = 1'b1;
        start_read(8'h05);
        watch(LAT + 6, 1'b0, 10, 8'h09, 8'h00);
        tests++; if (vk.size() != 1 || n_latch != 1) begin
            fails++; $display("FAIL busy_req_count got valid=%0d latch=%0d want 1/1", vk.size(), n_latch);
        end
        tests++; if (vd.size() < 1 || vd[0] !== 32'h12345678) begin
            fails++; $display("FAIL busy_req_data got=%h want=12345678", (vd.size() > 0) ? vd[0] : 32'hx);
        end
        tests++; if (addrOut !== 8'h05) begin
            fails++; $display("FAIL busy_req_addr got=%h want=05", addrOut);
        end
    endtask

    task automatic test_back_to_back();
        mem[8'h01] = 32'h00000001; present[8'h01] = 1'b1;
        mem[8'h02] = 32'h80000000; present[8'h02] = 1'b1;
        start_read(8'h01);
        watch(2 * PER, 1'b1, -1, 8'h00, 8'h02);
        tests++; if (vk.size() != 2 || n_latch != 2) begin
            fails++; $display("FAIL b2b_count got valid=%0d latch=%0d want 2/2", vk.size(), n_latch);
        end
        tests++; if (vk.size() != 2 || vk[0] != LAT || vk[1] - vk[0] != PER) begin
            fails++; $display("FAIL b2b_spacing got k0=%0d k1=%0d want %0d/%0d",
                              (vk.size() > 0) ? vk[0] : -1, (vk.size() > 1) ? vk[1] : -1, LAT, LAT + PER);
        end
        tests++; if (vd.size() != 2 || vd[0] !== 32'h00000001 || vd[1] !== 32'h80000000) begin
            fails++; $display("FAIL b2b_data got=%h,%h want=00000001,80000000",
                              (vd.size() > 0) ? vd[0] : 32'hx, (vd.size() > 1) ? vd[1] : 32'hx);
        end
        // let the pipeline drain back to IDLE
        watch(LAT + 3, 1'b0, -1, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid_shift();
        mem[8'h05] = 32'hA5A5A5A5; present[8'h05] = 1'b1;
        start_read(8'h05);
        for (int k = 0; k <= 10; k++) begin
            @(negedge bclk);
            if (k == 0) rdReq = 1'b0;
        end
        tests++; if (shiftEn !== 1'b1) begin
            fails++; $display("FAIL mid_pre_shift got shiftEn=%b want=1", shiftEn);
        end
        rstb = 1'b0;
        #1;
        tests++; if (shiftEn !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL mid_abort got shiftEn=%b busy=%b want 0/0", shiftEn, busy);
        end
        tests++; if (rdData !== '0 || addrOut !== 8'h00) begin
            fails++; $display("FAIL mid_clear got data=%h addr=%h want 0/00", rdData, addrOut);
        end
        repeat (2) @(negedge bclk);
        rstb = 1'b1;
        watch(LAT + 5, 1'b0, -1, 8'h00, 8'h00);
        tests++; if (vk.size() != 0 || rdData !== '0) begin
            fails++; $display("FAIL mid_no_valid got valid=%0d data=%h want 0/0", vk.size(), rdData);
        end
        start_read(8'h05);
        watch(LAT + 3, 1'b0, -1, 8'h00, 8'h00);
        tests++; if (vk.size() != 1 || vd[0] !== 32'hA5A5A5A5 || vk[0] != LAT) begin
            fails++; $display("FAIL mid_reread got n=%0d data=%h want 1/a5a5a5a5", vk.size(),
                              (vd.size() > 0) ? vd[0] : 32'hx);
        end
    endtask

    task automatic test_random_reads();
        for (int it = 0; it < 12; it++) begin
            logic [7:0]       a;
            logic [NBITS-1:0] exp_w;
            int               pk;
            a = 8'($urandom);
            present[a] = ($urandom_range(0, 3) != 0);
            mem[a]     = NBITS'($urandom);
            exp_w      = expect_word(a);
            pk         = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, LAT)) : -1;
            start_read(a);
            watch(LAT + 3, 1'b0, pk, 8'($urandom), 8'h00);
            tests++; if (vk.size() != 1 || vk[0] != LAT || vd[0] !== exp_w) begin
                fails++; $display("FAIL rand_read[%0d] addr=%h got n=%0d k=%0d data=%h want n=1 k=%0d data=%h",
                                  it, a, vk.size(), (vk.size() > 0) ? vk[0] : -1,
                                  (vd.size() > 0) ? vd[0] : 32'hx, LAT, exp_w);
            end
            tests++; if (addrOut !== a || rdData !== exp_w) begin
                fails++; $display("FAIL rand_hold[%0d] got addr=%h data=%h want %h/%h",
                                  it, addrOut, rdData, a, exp_w);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0; present[i] = 1'b0;
        end
        test_reset();
        test_single_read();
        test_addr_miss();
        test_req_while_busy();
        test_back_to_back();
        test_reset_mid_shift();
        test_random_reads();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
